// File: rtl/adder_driver.sv
// adder_driver: issues buffered operand pairs to the adder one at a time and
// collects the sums into a show-ahead result FIFO for the host.
// Optional build macro ADDER_DRV_CHECK_EN adds an expected-sum checker that
// drives the sticky mismatch flag; without it mismatch is tied low.
module adder_driver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = DATA_W + 1,
  parameter int unsigned ODEPTH = 4,
  parameter int unsigned RDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              add_valid,
  input  logic              add_ready,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic              sum_valid,
  output logic              sum_ready,
  input  logic [SUM_W-1:0]  sum_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_data,
  output logic              busy,
  output logic [15:0]       txn_count,
  output logic              mismatch
);

  localparam int unsigned OAW = $clog2(ODEPTH);
  localparam int unsigned RAW = $clog2(RDEPTH);
  localparam logic [OAW:0] OINC = (OAW + 1)'(1);
  localparam logic [RAW:0] RINC = (RAW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StCollect} state_e;

  state_e state_q, state_d;

  // Operand FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [2*DATA_W-1:0] omem [ODEPTH];
  logic [OAW:0]        owptr_q, orptr_q;
  logic                oempty, ofull, opush, opop;
  logic [DATA_W-1:0]   ohead_a, ohead_b;

  // Result FIFO, same pointer scheme.
  logic [SUM_W-1:0]    rmem [RDEPTH];
  logic [RAW:0]        rwptr_q, rrptr_q;
  logic                rempty, rfull, rpush, rpop;

  logic                add_valid_q;
  logic [DATA_W-1:0]   add_a_q, add_b_q;
  logic [15:0]         txn_q;

  assign oempty   = owptr_q == orptr_q;
  assign ofull    = (owptr_q[OAW] != orptr_q[OAW]) &&
                    (owptr_q[OAW-1:0] == orptr_q[OAW-1:0]);
  assign op_ready = !ofull;
  assign opush    = op_valid && !ofull;
  assign ohead_a  = omem[orptr_q[OAW-1:0]][2*DATA_W-1:DATA_W];
  assign ohead_b  = omem[orptr_q[OAW-1:0]][DATA_W-1:0];

  assign rempty    = rwptr_q == rrptr_q;
  assign rfull     = (rwptr_q[RAW] != rrptr_q[RAW]) &&
                     (rwptr_q[RAW-1:0] == rrptr_q[RAW-1:0]);
  assign res_valid = !rempty;
  assign res_data  = rmem[rrptr_q[RAW-1:0]];
  assign rpop      = !rempty && res_ready;

  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign busy      = state_q != StIdle;
  assign txn_count = txn_q;

  // FSM next state; sum_ready is only ever raised in COLLECT so a lingering
  // adder output valid cannot be captured twice.
  always_comb begin
    state_d   = state_q;
    opop      = 1'b0;
    rpush     = 1'b0;
    sum_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!oempty) begin
          opop    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (add_valid_q && add_ready) state_d = StCollect;
      end
      StCollect: begin
        sum_ready = !rfull;
        if (sum_valid && !rfull) begin
          rpush   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Adder request registers: load on pop, drop valid on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else if (opop) begin
      add_valid_q <= 1'b1;
      add_a_q     <= ohead_a;
      add_b_q     <= ohead_b;
    end else if (state_q == StIssue && add_valid_q && add_ready) begin
      add_valid_q <= 1'b0;
    end
  end

  // FIFO pointers and transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owptr_q <= '0;
      orptr_q <= '0;
      rwptr_q <= '0;
      rrptr_q <= '0;
      txn_q   <= '0;
    end else begin
      if (opush) owptr_q <= owptr_q + OINC;
      if (opop)  orptr_q <= orptr_q + OINC;
      if (rpush) rwptr_q <= rwptr_q + RINC;
      if (rpop)  rrptr_q <= rrptr_q + RINC;
      if (rpush) txn_q   <= txn_q + 16'd1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (opush) omem[owptr_q[OAW-1:0]] <= {op_a, op_b};
    if (rpush) rmem[rwptr_q[RAW-1:0]] <= sum_data;
  end

`ifdef ADDER_DRV_CHECK_EN
  logic [DATA_W:0]  exp_sum;
  logic [SUM_W-1:0] exp_q;
  logic             mismatch_q;

  assign exp_sum  = {1'b0, ohead_a} + {1'b0, ohead_b};
  assign mismatch = mismatch_q;

  // Expected sum latched with the operands; sticky flag set on a bad capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (opop) exp_q <= SUM_W'(exp_sum);
      if (rpush && (sum_data != exp_q)) mismatch_q <= 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_adder_driver.sv
// Self-checking bench for adder_driver with a behavioural adder model.
module tb_adder_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid, op_ready;
  logic [7:0] op_a, op_b;
  logic       add_valid, add_ready;
  logic [7:0] add_a, add_b;
  logic       sum_valid, sum_ready;
  logic [8:0] sum_data;
  logic       res_valid, res_ready;
  logic [8:0] res_data;
  logic       busy;
  logic [15:0] txn_count;
  logic       mismatch;

  // Model knobs: force a wrong sum, or hide the output valid.
  logic force_zero = 1'b0;
  logic stall_out  = 1'b0;
  logic sv_q;

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;
  logic exp_mm;

  always #5 clk = ~clk;

  adder_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .add_valid (add_valid),
    .add_ready (add_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .txn_count (txn_count),
    .mismatch  (mismatch)
  );

  // Adder model: result valid the cycle after the input handshake, held
  // until the output handshake.
  assign sum_valid = sv_q && !stall_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q     <= 1'b0;
      sum_data <= '0;
    end else begin
      if (sum_valid && sum_ready) sv_q <= 1'b0;
      if (add_valid && add_ready) begin
        sv_q     <= 1'b1;
        sum_data <= force_zero ? 9'd0 : ({1'b0, add_a} + {1'b0, add_b});
      end
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    check("op_ready", op_ready, 1);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, then pop it.
  task automatic pop_expect(input string name, input logic [8:0] exp);
    int n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, res_valid stayed 0, expected 1", name);
    end else begin
      check(name, res_data, exp);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic [8:0] b2b_exp[5];
    logic [7:0] b2b_a[5];
    logic [7:0] b2b_b[5];

    vecs[0] = '{8'd3,   8'd4,   9'd7};
    vecs[1] = '{8'd255, 8'd255, 9'h1FE};
    vecs[2] = '{8'd0,   8'd0,   9'd0};
    vecs[3] = '{8'd128, 8'd127, 9'd255};
    vecs[4] = '{8'd200, 8'd100, 9'd300};
    b2b_a   = '{8'd1, 8'd10, 8'd100, 8'd250, 8'd17};
    b2b_b   = '{8'd2, 8'd20, 8'd50,  8'd9,   8'd34};
    b2b_exp = '{9'd3, 9'd30, 9'd150, 9'd259, 9'd51};

    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    add_ready = 1'b1; res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_add_valid", add_valid, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_op_ready", op_ready, 1);
    check("rst_sum_ready", sum_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_txn", txn_count, 0);
    check("rst_mismatch", mismatch, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single transactions with an ideal adder.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].a, vecs[i].b);
      pop_expect($sformatf("vec%0d_res", i), vecs[i].s);
      exp_txn++;
      check($sformatf("vec%0d_txn", i), txn_count, exp_txn);
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_mismatch", i), mismatch, 0);
    end

    // Adder input stall: request held stable for 10 cycles.
    add_ready = 1'b0;
    push(8'd5, 8'd6);
    check("stall_valid_early", add_valid, 0);
    @(negedge clk);
    check("stall_valid_rise", add_valid, 1);
    check("stall_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid_hold", add_valid, 1);
      check("stall_a_hold", add_a, 5);
      check("stall_b_hold", add_b, 6);
    end
    add_ready = 1'b1;
    @(negedge clk);
    check("stall_valid_drop", add_valid, 0);
    pop_expect("stall_res", 9'd11);
    exp_txn++;
    check("stall_txn", txn_count, exp_txn);

    // Five back-to-back pushes into a 4-deep result FIFO with no pops.
    for (int i = 0; i < 5; i++) push(b2b_a[i], b2b_b[i]);
    repeat (30) @(negedge clk);
    check("b2b_res_valid", res_valid, 1);
    check("b2b_busy", busy, 1);
    check("b2b_sum_ready", sum_ready, 0);
    check("b2b_txn_stalled", txn_count, exp_txn + 4);
    for (int i = 0; i < 5; i++) pop_expect($sformatf("b2b_res%0d", i), b2b_exp[i]);
    exp_txn += 5;
    @(negedge clk);
    check("b2b_txn", txn_count, exp_txn);
    check("b2b_empty", res_valid, 0);

    // Wrong adder sum raises the sticky flag only when checking is built in.
`ifdef ADDER_DRV_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    force_zero = 1'b1;
    push(8'd1, 8'd1);
    pop_expect("mm_res", 9'd0);
    force_zero = 1'b0;
    check("mm_set", mismatch, exp_mm);
    push(8'd2, 8'd2);
    pop_expect("mm_res2", 9'd4);
    check("mm_sticky", mismatch, exp_mm);
    exp_txn += 2;
    check("mm_txn", txn_count, exp_txn);

    // Reset while in COLLECT with two operands queued.
    stall_out = 1'b1;
    push(8'd7, 8'd8);
    push(8'd9, 8'd9);
    push(8'd1, 8'd0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_sum_ready", sum_ready, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_add_valid", add_valid, 0);
    check("mid_rst_add_a", add_a, 0);
    check("mid_rst_add_b", add_b, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_op_ready", op_ready, 1);
    check("mid_rst_sum_ready", sum_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_txn", txn_count, 0);
    check("mid_rst_mismatch", mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_out = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_add_valid", add_valid, 0);
    check("post_rst_txn", txn_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
